// File: rtl/board_pkg.sv
// Shared types and constants for the gravity board loader.
package board_pkg;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_COL_FULL  = 2'd1,
        ST_BAD_COL   = 2'd2,
        ST_BAD_PIECE = 2'd3
    } drop_status_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WRITE = 2'd2,
        S_CLEAR = 2'd3
    } loader_state_t;

    localparam int unsigned EMPTY_CELL = '0;

endpackage

// File: rtl/column_stack.sv
// One board column: a stack of cells filled bottom-up, with a height counter.
module column_stack #(
    parameter  int unsigned ROWS   = 6,
    parameter  int unsigned CELL_W = 2,
    localparam int unsigned ROW_W  = $clog2(ROWS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     clr,
    input  logic [CELL_W-1:0]        piece,
    output logic [ROW_W-1:0]         height,
    output logic                     full,
    output logic [ROWS*CELL_W-1:0]   cells
);

    logic [ROW_W-1:0]       height_q;
    logic [ROWS*CELL_W-1:0] cells_q;

    // Clear wins over push; a full column is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            height_q <= '0;
            cells_q  <= '0;
        end else if (clr) begin
            height_q <= '0;
            cells_q  <= '0;
        end else if (push && !full) begin
            for (int r = 0; r < ROWS; r++) begin
                if (height_q == ROW_W'(r)) begin
                    cells_q[r*CELL_W +: CELL_W] <= piece;
                end
            end
            height_q <= height_q + ROW_W'(1);
        end
    end

    // Expose state; full is a plain decode of the height.
    always_comb begin
        height = height_q;
        cells  = cells_q;
        full   = (height_q == ROW_W'(ROWS));
    end

endmodule

// File: rtl/gravity_board_loader.sv
// COLS x ROWS gravity board: drop handshake, validity checks, status report and column-wise clear.
module gravity_board_loader
    import board_pkg::*;
#(
    parameter  int unsigned COLS   = 7,
    parameter  int unsigned ROWS   = 6,
    parameter  int unsigned CELL_W = 2,
    localparam int unsigned COL_W  = $clog2(COLS),
    localparam int unsigned ROW_W  = $clog2(ROWS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          drop_valid,
    output logic                          drop_ready,
    input  logic [COL_W-1:0]              drop_col,
    input  logic [CELL_W-1:0]             drop_piece,
    input  logic                          clear,
    output logic                          done,
    output logic [1:0]                    status,
    output logic [COL_W-1:0]              placed_col,
    output logic [ROW_W-1:0]              placed_row,
    output logic                          board_full,
    output logic [COLS*ROWS*CELL_W-1:0]   board_flat
);

    loader_state_t     state_q, state_d;
    logic [COL_W-1:0]  col_q, clr_cnt_q, placed_col_q;
    logic [CELL_W-1:0] piece_q;
    logic              done_q, board_full_q, board_full_d, accept;
    drop_status_t      status_q, chk_status;
    logic [ROW_W-1:0]  placed_row_q, sel_height;
    logic [COLS-1:0]   push, clr, col_full, will_full;
    logic [ROW_W-1:0]  heights [COLS];

    for (genvar c = 0; c < COLS; c++) begin : g_col
        column_stack #(
            .ROWS   (ROWS),
            .CELL_W (CELL_W)
        ) u_col (
            .clk    (clk),
            .rst    (rst),
            .push   (push[c]),
            .clr    (clr[c]),
            .piece  (piece_q),
            .height (heights[c]),
            .full   (col_full[c]),
            .cells  (board_flat[c*ROWS*CELL_W +: ROWS*CELL_W])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: clear has priority over a drop in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (clear)           state_d = S_CLEAR;
                else if (drop_valid) state_d = S_CHECK;
            end
            S_CHECK: state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            S_CLEAR: if (clr_cnt_q == COL_W'(COLS - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Drop validation on the captured column/piece; bad column is checked first
    // so an out-of-range index never selects a height.
    always_comb begin
        sel_height = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_q == COL_W'(c)) sel_height = heights[c];
        end
        if (32'(col_q) >= COLS)                     chk_status = ST_BAD_COL;
        else if (piece_q == CELL_W'(EMPTY_CELL))    chk_status = ST_BAD_PIECE;
        else if (sel_height == ROW_W'(ROWS))        chk_status = ST_COL_FULL;
        else                                        chk_status = ST_OK;
    end

    // Outputs and per-column strobes.
    always_comb begin
        drop_ready = (state_q == S_IDLE) && !clear;
        accept     = drop_valid && drop_ready;
        for (int c = 0; c < COLS; c++) begin
            push[c]      = (state_q == S_CHECK) && (chk_status == ST_OK) && (col_q == COL_W'(c));
            clr[c]       = (state_q == S_CLEAR) && (clr_cnt_q == COL_W'(c));
            will_full[c] = col_full[c] || (push[c] && (heights[c] == ROW_W'(ROWS - 1)));
        end
        board_full_d = board_full_q;
        if (state_q == S_CHECK && chk_status == ST_OK) board_full_d = &will_full;
        else if (state_q == S_CLEAR)                   board_full_d = 1'b0;
        done       = done_q;
        status     = status_q;
        placed_col = placed_col_q;
        placed_row = placed_row_q;
        board_full = board_full_q;
    end

    // Capture, clear counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            piece_q      <= '0;
            clr_cnt_q    <= '0;
            done_q       <= 1'b0;
            status_q     <= ST_OK;
            placed_col_q <= '0;
            placed_row_q <= '0;
            board_full_q <= 1'b0;
        end else begin
            if (accept) begin
                col_q   <= drop_col;
                piece_q <= drop_piece;
            end
            if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + COL_W'(1);
            else                    clr_cnt_q <= '0;
            done_q <= (state_q == S_CHECK);
            if (state_q == S_CHECK) begin
                status_q     <= chk_status;
                placed_col_q <= col_q;
                placed_row_q <= (chk_status == ST_OK) ? sel_height : '0;
            end
            board_full_q <= board_full_d;
        end
    end

endmodule

// File: tb/tb_gravity_board_loader.sv
// Scoreboard bench for gravity_board_loader (COLS=7, ROWS=6, CELL_W=2).
module tb_gravity_board_loader;

    localparam int COLS   = 7;
    localparam int ROWS   = 6;
    localparam int CELL_W = 2;
    localparam int COL_W  = 3;
    localparam int ROW_W  = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        drop_valid, drop_ready, clear, done, board_full;
    logic [COL_W-1:0]            drop_col, placed_col;
    logic [CELL_W-1:0]           drop_piece;
    logic [1:0]                  status;
    logic [ROW_W-1:0]            placed_row;
    logic [COLS*ROWS*CELL_W-1:0] board_flat;

    typedef struct {
        int status;
        int col;
        int row;
    } exp_t;

    exp_t sb[$];
    int   mdl [COLS][ROWS];
    int   mh  [COLS];
    int   tests_run    = 0;
    int   tests_failed = 0;

    gravity_board_loader #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CELL_W (CELL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .drop_valid (drop_valid),
        .drop_ready (drop_ready),
        .drop_col   (drop_col),
        .drop_piece (drop_piece),
        .clear      (clear),
        .done       (done),
        .status     (status),
        .placed_col (placed_col),
        .placed_row (placed_row),
        .board_full (board_full),
        .board_flat (board_flat)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int c = 0; c < COLS; c++) begin
            mh[c] = 0;
            for (int r = 0; r < ROWS; r++) mdl[c][r] = 0;
        end
    endtask

    task automatic check_board(input string name);
        logic [COLS*ROWS*CELL_W-1:0] exp_flat;
        exp_flat = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                exp_flat[(c*ROWS+r)*CELL_W +: CELL_W] = CELL_W'(mdl[c][r]);
        tests_run++;
        if (board_flat !== exp_flat) begin
            tests_failed++;
            $display("FAIL %s: board_flat got %h expected %h", name, board_flat, exp_flat);
        end
    endtask

    task automatic expect_drop(input int col, input int piece);
        exp_t e;
        e.col = col;
        e.row = 0;
        if (col >= COLS)            e.status = 2;
        else if (piece == 0)        e.status = 3;
        else if (mh[col] == ROWS)   e.status = 1;
        else begin
            e.status = 0;
            e.row    = mh[col];
            mdl[col][mh[col]] = piece;
            mh[col]++;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge with an acceptable drop presented.
    task automatic finish_drop(input string name);
        int   lat;
        bit   got;
        bit   exp_full;
        exp_t e;
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        drop_col   = COL_W'($urandom);
        drop_piece = CELL_W'($urandom);
        lat = 1;
        got = 1'b0;
        while (lat <= 6) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        exp_full = 1'b1;
        for (int c = 0; c < COLS; c++) if (mh[c] != ROWS) exp_full = 1'b0;
        tests_run++;
        if (!got || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL %s_done: done seen %0d scoreboard entries %0d, required 1 and >0",
                     name, got, sb.size());
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            tests_run += 4;
            if (lat != 2) begin
                tests_failed++;
                $display("FAIL %s_latency: got %0d expected 2", name, lat);
            end
            if (status !== 2'(e.status)) begin
                tests_failed++;
                $display("FAIL %s_status: got %0d expected %0d", name, status, e.status);
            end
            if (placed_col !== COL_W'(e.col) || placed_row !== ROW_W'(e.row)) begin
                tests_failed++;
                $display("FAIL %s_placed: got col %0d row %0d expected col %0d row %0d",
                         name, placed_col, placed_row, e.col, e.row);
            end
            if (board_full !== exp_full) begin
                tests_failed++;
                $display("FAIL %s_full: got %0d expected %0d", name, board_full, exp_full);
            end
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_pulse: done got %0d expected 0", name, done);
        end
        check_board(name);
    endtask

    task automatic drop(input int col, input int piece, input string name);
        int n;
        n = 0;
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = COL_W'(col);
        drop_piece = CELL_W'(piece);
        while (!drop_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!drop_ready) begin
            tests_failed++;
            $display("FAIL %s_accept: drop_ready got 0 expected 1 within 50 cycles", name);
            drop_valid = 1'b0;
            return;
        end
        expect_drop(col, piece);
        finish_drop(name);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b0;
        drop_valid = 1'b0;
        clear      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || status !== 2'd0 || placed_col !== '0 || placed_row !== '0 ||
            board_full !== 1'b0 || board_flat !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: done %0d status %0d col %0d row %0d full %0d flat %h, required all 0",
                     done, status, placed_col, placed_row, board_full, board_flat);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (drop_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %0d expected 1", drop_ready);
        end
        model_clear();
    endtask

    task automatic test_single_drop();
        drop(3, 1, "single");
    endtask

    task automatic test_column_fill();
        for (int i = 0; i < ROWS; i++) drop(0, (i % 2) + 1, "colfill");
        drop(0, 1, "colfull");
    endtask

    task automatic test_bad_inputs();
        drop(7, 1, "bad_col");
        drop(2, 0, "bad_piece");
        drop(7, 0, "bad_precedence");
    endtask

    task automatic test_clear_priority();
        int n;
        @(negedge clk);
        clear      = 1'b1;
        drop_valid = 1'b1;
        drop_col   = 3'd4;
        drop_piece = 2'd2;
        #1;
        tests_run++;
        if (drop_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_ready_req: got %0d expected 0", drop_ready);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (drop_ready) break;
            n++;
        end
        tests_run++;
        if (n != COLS) begin
            tests_failed++;
            $display("FAIL clr_busy_cycles: got %0d expected %0d", n, COLS);
        end
        model_clear();
        check_board("clr_board");
        tests_run++;
        if (board_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_full: got %0d expected 0", board_full);
        end
        expect_drop(4, 2);
        finish_drop("clr_held_drop");
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = 3'd5;
        drop_piece = 2'd1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        drop_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || board_flat !== '0 || board_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_state: done %0d flat %h full %0d, required 0 0 0",
                     done, board_flat, board_full);
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        tests_run++;
        if (drop_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_ready: got %0d expected 1", drop_ready);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL rstmid_no_done: done seen 1 expected 0");
        end
        check_board("rstmid_board");
    endtask

    task automatic test_fill_board();
        int n;
        apply_reset();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                drop(c, 1 + ((c + r) % 3), "fill");
        drop(2, 3, "full_drop");
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (drop_ready) break;
            n++;
        end
        model_clear();
        tests_run++;
        if (board_full !== 1'b0 || n >= 20) begin
            tests_failed++;
            $display("FAIL fill_clear_full: full %0d wait %0d, required 0 and <20", board_full, n);
        end
        check_board("fill_clear_board");
    endtask

    initial begin
        rst        = 1'b0;
        drop_valid = 1'b0;
        drop_col   = '0;
        drop_piece = '0;
        clear      = 1'b0;
        model_clear();
        test_reset();
        test_single_drop();
        test_column_fill();
        test_bad_inputs();
        test_clear_priority();
        test_reset_mid();
        test_fill_board();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
